// File: rtl/perf_stats_uart_tx.sv
// Snapshots five core performance counters on request and streams them out as a
// 14-byte 8N1 UART frame: sync byte, little-endian counters, then an XOR checksum.
module perf_stats_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 651
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [27:0] clk_cycles,
  input  logic [12:0] retired_instructions,
  input  logic [12:0] predictions_made,
  input  logic [12:0] correct_predictions,
  input  logic [12:0] invalid_clk_cycles,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LastByte = 4'd13;

  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [3:0]  byte_q;
  logic [27:0] cyc_q;
  logic [12:0] ret_q;
  logic [12:0] pred_q;
  logic [12:0] cor_q;
  logic [12:0] inv_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic [95:0]  payload_d;
  logic [111:0] frame_d;
  logic [7:0]   cur_byte_d;
  logic [2:0]   next_bit_d;
  logic         bit_end_d;

  function automatic logic [7:0] xor_fold(input logic [95:0] p);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 12; i++) begin
      acc = acc ^ p[i*8 +: 8];
    end
    return acc;
  endfunction

  // Frame image built from the snapshot; byte 0 sits in the low bits.
  always_comb begin
    payload_d  = {3'b000, inv_q, 3'b000, cor_q, 3'b000, pred_q, 3'b000, ret_q, 4'h0, cyc_q};
    frame_d    = {xor_fold(payload_d), payload_d, 8'hA5};
    cur_byte_d = frame_d[{byte_q, 3'b000} +: 8];
    next_bit_d = bit_q + 3'd1;
    bit_end_d  = (baud_q == BaudLast);
  end

  // Serializer FSM; every output is a register so start never reaches a pin combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      cyc_q   <= 28'd0;
      ret_q   <= 13'd0;
      pred_q  <= 13'd0;
      cor_q   <= 13'd0;
      inv_q   <= 13'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= 16'd0;
          bit_q  <= 3'd0;
          byte_q <= 4'd0;
          if (start) begin
            cyc_q   <= clk_cycles;
            ret_q   <= retired_instructions;
            pred_q  <= predictions_made;
            cor_q   <= correct_predictions;
            inv_q   <= invalid_clk_cycles;
            state_q <= START_BIT;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START_BIT: begin
          if (bit_end_d) begin
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            tx_q    <= cur_byte_d[0];
            state_q <= DATA_BITS;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA_BITS: begin
          if (bit_end_d) begin
            baud_q <= 16'd0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP_BIT;
            end else begin
              bit_q <= next_bit_d;
              tx_q  <= cur_byte_d[next_bit_d];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP_BIT: begin
          if (bit_end_d) begin
            baud_q <= 16'd0;
            if (byte_q < LastByte) begin
              byte_q  <= byte_q + 4'd1;
              tx_q    <= 1'b0;
              state_q <= START_BIT;
            end else begin
              byte_q  <= 4'd0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_perf_stats_uart_tx.sv
// Directed bench: decodes the serial line with a bench-side UART receiver and
// compares frames, busy length and done pulses against hand-computed values.
module tb_perf_stats_uart_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start2;
  logic [27:0] cyc_in;
  logic [12:0] ret_in;
  logic [12:0] pred_in;
  logic [12:0] cor_in;
  logic [12:0] inv_in;
  logic        tx;
  logic        busy;
  logic        done;
  logic        tx2;
  logic        busy2;
  logic        done2;

  int n_checks = 0;
  int n_fail   = 0;
  logic scramble = 1'b0;

  perf_stats_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .clk_cycles(cyc_in),
    .retired_instructions(ret_in), .predictions_made(pred_in),
    .correct_predictions(cor_in), .invalid_clk_cycles(inv_in),
    .tx(tx), .busy(busy), .done(done)
  );

  perf_stats_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .clk_cycles(cyc_in),
    .retired_instructions(ret_in), .predictions_made(pred_in),
    .correct_predictions(cor_in), .invalid_clk_cycles(inv_in),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running observation counters; tests compare deltas.
  int   cyc_cnt = 0;
  int   last_edge = 0;
  int   busy_total = 0;
  int   done_total = 0;
  int   frames_total = 0;
  int   done_bad = 0;
  int   space_err = 0;
  int   busy2_total = 0;
  int   done2_total = 0;
  logic tx_prev = 1'b1;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (tx !== tx_prev) begin
      if (busy && busy_prev && (((cyc_cnt - last_edge) % CPB) != 0)) space_err <= space_err + 1;
      last_edge <= cyc_cnt;
    end
    tx_prev   <= tx;
    busy_prev <= busy;
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    if (done === 1'b1 && (tx !== 1'b1 || busy !== 1'b0)) done_bad <= done_bad + 1;
    if (busy === 1'b1 && busy_prev === 1'b0) frames_total <= frames_total + 1;
    if (busy2 === 1'b1) busy2_total <= busy2_total + 1;
    if (done2 === 1'b1) done2_total <= done2_total + 1;
  end

  // Counters wander every cycle once a frame has been accepted.
  always @(negedge clk) begin
    if (scramble) begin
      cyc_in  = 28'($urandom());
      ret_in  = 13'($urandom());
      pred_in = 13'($urandom());
      cor_in  = 13'($urandom());
      inv_in  = 13'($urandom());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(t < 2000), 32'd1);
  endtask

  // Bench-side UART receiver sampling at bit centres.
  task automatic decode_check(input logic [111:0] exp, input string nm);
    int t;
    int ferr;
    logic [7:0] b;
    logic [7:0] e;
    t = 0;
    ferr = 0;
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_start_seen"}, 32'(tx), 32'd0);
    for (int k = 0; k < 14; k++) begin
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ferr++;
      repeat (CPB / 2) @(negedge clk);
      e = exp[111 - 8*k -: 8];
      chk($sformatf("%s_byte%0d", nm, k), 32'(b), 32'(e));
    end
    chk({nm, "_framing"}, 32'(ferr), 32'd0);
  endtask

  typedef struct {
    logic [27:0]  cyc;
    logic [12:0]  ret;
    logic [12:0]  pred;
    logic [12:0]  cor;
    logic [12:0]  inv;
    logic [111:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string nm);
    int b0;
    int d0;
    @(negedge clk);
    cyc_in  = v.cyc;
    ret_in  = v.ret;
    pred_in = v.pred;
    cor_in  = v.cor;
    inv_in  = v.inv;
    start   = 1'b1;
    b0 = busy_total;
    d0 = done_total;
    @(negedge clk);
    start    = 1'b0;
    scramble = 1'b1;
    decode_check(v.exp, nm);
    scramble = 1'b0;
    repeat (4) @(negedge clk);
    chk({nm, "_busy_cycles"}, 32'(busy_total - b0), 32'(140 * CPB));
    chk({nm, "_done_pulses"}, 32'(done_total - d0), 32'd1);
  endtask

  initial begin
    int b0;
    int d0;
    int f0;
    int dn;
    logic done_prev;

    vecs[0] = '{28'h0123456, 13'h1ABC, 13'h0010, 13'h000C, 13'h0003,
                112'hA5_56_34_12_00_BC_1A_10_00_0C_00_03_00_C9};
    vecs[1] = '{28'hFFFFFFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF,
                112'hA5_FF_FF_FF_0F_FF_1F_FF_1F_FF_1F_FF_1F_F0};
    vecs[2] = '{28'h0000000, 13'h0000, 13'h0000, 13'h0000, 13'h0000,
                112'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00};
    vecs[3] = '{28'h8000001, 13'h0001, 13'h1000, 13'h0FF0, 13'h1234,
                112'hA5_01_00_00_08_01_00_00_10_F0_0F_34_12_C1};

    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    cyc_in = 28'd0; ret_in = 13'd0; pred_in = 13'd0; cor_in = 13'd0; inv_in = 13'd0;
    #2 rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame.
    @(negedge clk);
    cyc_in = 28'h0123456;
    start  = 1'b1;
    d0 = done_total;
    b0 = busy_total;
    @(negedge clk);
    start = 1'b0;
    scramble = 1'b1;
    begin
      int t;
      t = 0;
      while ((busy_total - b0) < 200 && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk("abort_reach200", 32'(t < 400), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    scramble = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_total - d0), 32'd0);
    chk("abort_no_resume", 32'(busy), 32'd0);
    run_vec(vecs[0], "after_abort");

    // Start held high: two frames back to back, second one starting right after done.
    @(negedge clk);
    f0 = frames_total;
    d0 = done_total;
    start = 1'b1;
    done_prev = 1'b0;
    dn = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (done_prev) begin
        dn++;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_tx", 32'(tx), 32'd0);
      end
      done_prev = done;
    end
    start = 1'b0;
    wait_idle("b2b_idle_timeout");
    repeat (4) @(negedge clk);
    chk("b2b_done_seen", 32'(dn), 32'd1);
    chk("b2b_frames", 32'(frames_total - f0), 32'd2);
    chk("b2b_done_total", 32'(done_total - d0), 32'd2);

    // Start pulses while busy must not queue another frame.
    @(negedge clk);
    f0 = frames_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle("mid_idle_timeout");
    repeat (50) @(negedge clk);
    chk("mid_frames", 32'(frames_total - f0), 32'd1);
    chk("mid_busy_after", 32'(busy), 32'd0);

    // Faster baud instance.
    @(negedge clk);
    b0 = busy2_total;
    d0 = done2_total;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (300) @(negedge clk);
    chk("cpb2_busy_cycles", 32'(busy2_total - b0), 32'd280);
    chk("cpb2_done", 32'(done2_total - d0), 32'd1);
    chk("cpb2_tx_idle", 32'(tx2), 32'd1);

    chk("bit_spacing_errors", 32'(space_err), 32'd0);
    chk("done_cycle_state_errors", 32'(done_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
